clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_WIDTH, default 16, width of the divide-ratio and period counter.
REQ-003 Parameter DEFAULT_DIV, default 4, divide ratio loaded at reset; 4 gives 25 MHz from 100 MHz.
REQ-004 clk_100mhz  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  CHANNELS  per-channel run enable, level-sensitive.
REQ-007 div_wr  input  1  write strobe for a ratio, one cycle per write.
REQ-008 div_sel  input  clog2(CHANNELS), minimum 1  channel index for div_wr.
REQ-009 div_data  input  CNT_WIDTH  new divide ratio N.
REQ-010 clk_out  output  CHANNELS  divided square wave per channel, registered.
REQ-011 tick  output  CHANNELS  one-cycle pulse per channel, coincident with each clk_out period start, registered.

Function
REQ-012 Each channel SHALL hold a shadow ratio S, an active ratio A, a period counter C, and a state of IDLE or RUN.
REQ-013 When div_wr=1 and div_sel<CHANNELS, the selected channel's S SHALL take div_data at that edge; div_sel>=CHANNELS SHALL be ignored.
REQ-014 In IDLE, C=0, clk_out=0 and tick=0.
REQ-015 IDLE->RUN SHALL occur on the first edge with en=1; at that edge A<=S, C<=0, clk_out<=1 (or 0 if S=0), tick<=1 (or 0 if S=0).
REQ-016 In RUN with A>=2, C SHALL increment each cycle and wrap from A-1 to 0.
REQ-017 In RUN with A>=2, clk_out SHALL be 1 for C in [0, H-1] and 0 otherwise, with H=(A+1)>>1; odd ratios are high for one extra cycle.
REQ-018 tick SHALL be 1 exactly in cycles where C=0 in RUN.
REQ-019 At each wrap edge, A<=S, so a ratio change takes effect only at a period boundary and no runt or glitch pulse is produced.
REQ-020 A write landing on the same edge as a wrap SHALL update S only; the wrap loads the pre-write S, and the new value applies at the following boundary.
REQ-021 A=1 SHALL hold clk_out=1 with tick=1 every cycle.
REQ-022 A=0 SHALL hold clk_out=0, tick=0 and C=0 while in RUN; a later write of N>0 SHALL be picked up within one cycle, and that edge SHALL be treated as a period start.
REQ-023 en falling to 0 SHALL force IDLE at the next edge, regardless of C; the partial period is abandoned and clk_out=0.
REQ-024 Channels SHALL be fully independent, with no cross-channel phase alignment.
REQ-025 Output latency from en rising to the first tick SHALL be exactly one edge.
REQ-026 Counter arithmetic SHALL be unsigned CNT_WIDTH, and the maximum ratio SHALL be 2^CNT_WIDTH-1.

Reset
REQ-027 While rst=1, every channel SHALL have S=A=DEFAULT_DIV, C=0, state IDLE, clk_out=0 and tick=0, with outputs cleared asynchronously.
REQ-028 Reset asserted mid-period SHALL abandon the period immediately, and no further tick SHALL appear until rst=0 and en=1.
REQ-029 Writes presented while rst=1 SHALL be discarded.

Structure
REQ-030 A shared package SHALL hold DEFAULT_DIV, the IDLE/RUN state encoding, and the clog2-based select-width helper.
REQ-031 One sub-module, clk_div_channel, SHALL implement a single channel (S, A, C, FSM, outputs).
REQ-032 clk_div_bank SHALL instantiate CHANNELS copies of clk_div_channel via generate, plus the write decode.
REQ-033 No derived signal SHALL be used as a clock anywhere in the design; consumers use tick as an enable.

Verification
REQ-034 Reset release, en[0]=1, ratio 4 -> clk_out[0]=1,1,0,0 repeating; tick every 4th cycle, starting one edge after en.
REQ-035 Write N=5 to channel 1 then enable -> clk_out[1]=1,1,1,0,0 repeating; tick period 5.
REQ-036 Channel 0 running N=4, write N=6 at C=1 -> current period completes as 4, then period 6 with pattern 111000; no short pulse.
REQ-037 Write N=8 on the same edge as the wrap of an N=4 channel -> one further period of 4, then 8.
REQ-038 Drop en at C=2, and separately assert rst at C=1 -> clk_out=0 and tick=0 from the next edge (en case) or immediately (rst case); re-enable gives a clean 1,1,0,0 start.
REQ-039 N=0 then N=1 on channel 3 -> outputs held low, then clk_out=1 with tick every cycle; channels 0-2 remain unaffected throughout.

Source files
------------

// File: rtl/clk_div_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank_pkg
// Brief    : Shared constants, channel state encoding and select-width helper
//            for the clock divider bank.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_bank_pkg;

    // Ratio loaded into every channel at reset: 100 MHz / 4 = 25 MHz.
    localparam int c_default_div = 4;

    // Per-channel run state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    // Width of the channel-select bus; a single channel still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : clk_div_bank_pkg
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_channel
// Brief    : One divider channel: shadow/active ratio, period counter,
//            IDLE/RUN FSM and registered clk_out/tick outputs.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_channel
    import clk_div_bank_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_wr_en,
    input  logic [CNT_WIDTH-1:0] i_wr_data,
    output logic                 o_clk_out,
    output logic                 o_tick
);

    localparam logic [CNT_WIDTH-1:0] c_reset_div = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   c_one_w     = (CNT_WIDTH + 1)'(1);

    chan_state_t          r_state;
    logic [CNT_WIDTH-1:0] r_shadow;
    logic [CNT_WIDTH-1:0] r_active;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clk_out;
    logic                 r_tick;

    chan_state_t          w_state_nxt;
    logic [CNT_WIDTH-1:0] w_active_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic [CNT_WIDTH:0]   w_half;
    logic                 w_clk_nxt;
    logic                 w_tick_nxt;
    logic                 w_period_start;

    // High-phase length, computed one bit wider so the maximum ratio cannot overflow.
    assign w_half    = ({1'b0, r_active} + c_one_w) >> 1;
    assign w_cnt_inc = r_cnt + c_one;

    // Shadow ratio: written any time, consumed only at period starts.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_shadow <= c_reset_div;
        end else if (i_wr_en) begin
            r_shadow <= i_wr_data;
        end
    end

    // State, active ratio, counter and output registers.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_active  <= c_reset_div;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_active  <= w_active_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    // Next-state logic; a period start reloads the active ratio from the
    // pre-write shadow value so a change never cuts a period short.
    always_comb begin
        w_state_nxt    = r_state;
        w_active_nxt   = r_active;
        w_cnt_nxt      = '0;
        w_clk_nxt      = 1'b0;
        w_tick_nxt     = 1'b0;
        w_period_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_nxt    = ST_RUN;
                    w_period_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_active == '0) begin
                    // Parked at ratio 0 until a non-zero ratio is written.
                    w_period_start = (r_shadow != '0);
                end else if (r_cnt == (r_active - c_one)) begin
                    w_period_start = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_clk_nxt = ({1'b0, w_cnt_inc} < w_half);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_period_start) begin
            w_active_nxt = r_shadow;
            w_cnt_nxt    = '0;
            w_clk_nxt    = (r_shadow != '0);
            w_tick_nxt   = (r_shadow != '0);
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule : clk_div_channel
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Brief    : Bank of independent clock-enable dividers driven from the
//            100 MHz clock, with a shared ratio write port.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  logic                           clk_100mhz,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            en,
    input  logic                           div_wr,
    input  logic [sel_width(CHANNELS)-1:0] div_sel,
    input  logic [CNT_WIDTH-1:0]           div_data,
    output logic [CHANNELS-1:0]            clk_out,
    output logic [CHANNELS-1:0]            tick
);

    localparam int c_sel_w = sel_width(CHANNELS);

    // One channel per index; a select value with no matching index is ignored.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
        localparam logic [c_sel_w-1:0] c_idx = c_sel_w'(gi);
        logic w_wr_en;

        assign w_wr_en = div_wr && (div_sel == c_idx);

        clk_div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk_100mhz (clk_100mhz),
            .rst        (rst),
            .i_en       (en[gi]),
            .i_wr_en    (w_wr_en),
            .i_wr_data  (div_data),
            .o_clk_out  (clk_out[gi]),
            .o_tick     (tick[gi])
        );
    end

endmodule : clk_div_bank
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Directed, table-driven bench for clk_div_bank (4 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int c_ch = 4;
    localparam int c_w  = 16;

    logic            clk_100mhz;
    logic            rst;
    logic [c_ch-1:0] en;
    logic            div_wr;
    logic [1:0]      div_sel;
    logic [c_w-1:0]  div_data;
    logic [c_ch-1:0] clk_out;
    logic [c_ch-1:0] tick;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [3:0]  en;
        logic        wr;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  exp_clk;
        logic [3:0]  exp_tick;
    } vec_t;

    vec_t vecs[13];

    clk_div_bank #(
        .CHANNELS    (c_ch),
        .CNT_WIDTH   (c_w),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .en         (en),
        .div_wr     (div_wr),
        .div_sel    (div_sel),
        .div_data   (div_data),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later; write strobes last exactly one edge.
    task automatic step();
        @(posedge clk_100mhz);
        #1;
        div_wr = 1'b0;
    endtask

    // Expected patterns are read MSB-first: leftmost bit is the first cycle.
    task automatic expect_seq(input string name, input int ch, input int n,
                              input logic [31:0] pc, input logic [31:0] pt);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s clk c%0d", name, i), 32'(clk_out[ch]), 32'(pc[n-1-i]));
            check($sformatf("%s tick c%0d", name, i), 32'(tick[ch]), 32'(pt[n-1-i]));
        end
    endtask

    task automatic do_reset(input string name);
        en  = '0;
        rst = 1'b1;
        #1;
        check({name, " rst clk"}, 32'(clk_out), 32'(0));
        check({name, " rst tick"}, 32'(tick), 32'(0));
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Channels 0 and 1: ratio 4 (reset default) and ratio 5, enabled together.
        vecs[0]  = '{4'b0000, 1'b1, 2'd1, 16'd5, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0011};
        vecs[2]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
        vecs[3]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
        vecs[4]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001};
        vecs[6]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0010};
        vecs[7]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
        vecs[8]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
        vecs[9]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001};
        vecs[10] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
        vecs[11] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0010};
        vecs[12] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};

        // Reset, with a write to channel 0 that must be discarded.
        rst      = 1'b1;
        en       = '0;
        div_wr   = 1'b1;
        div_sel  = 2'd0;
        div_data = 16'd2;
        step();
        step();
        check("reset clk", 32'(clk_out), 32'(0));
        check("reset tick", 32'(tick), 32'(0));
        rst = 1'b0;

        for (int v = 0; v < 13; v++) begin
            en       = vecs[v].en;
            div_wr   = vecs[v].wr;
            div_sel  = vecs[v].sel;
            div_data = vecs[v].data;
            step();
            check($sformatf("vec%0d clk", v), 32'(clk_out), 32'(vecs[v].exp_clk));
            check($sformatf("vec%0d tick", v), 32'(tick), 32'(vecs[v].exp_tick));
        end

        // Ratio 4 -> 6 written mid-period: current period finishes as 4.
        do_reset("chg");
        en = 4'b0001;
        expect_seq("chg_pre", 0, 2, 32'b11, 32'b10);
        div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd6;
        expect_seq("chg_post", 0, 9, 32'b001110001, 32'b001000001);

        // Ratio 8 written on the wrap edge of a ratio-4 period.
        do_reset("wrap");
        en = 4'b0001;
        expect_seq("wrap_pre", 0, 4, 32'b1100, 32'b1000);
        div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd8;
        expect_seq("wrap_post", 0, 13, 32'b1100111100001, 32'b1000100000001);

        // Enable dropped at C=2, then re-enabled.
        do_reset("endrop");
        en = 4'b0001;
        expect_seq("endrop_run", 0, 3, 32'b110, 32'b100);
        en = 4'b0000;
        expect_seq("endrop_off", 0, 3, 32'b000, 32'b000);
        en = 4'b0001;
        expect_seq("endrop_re", 0, 5, 32'b11001, 32'b10001);

        // Reset asserted at C=1 while clk_out is high: outputs clear at once.
        do_reset("rstmid");
        en = 4'b0001;
        expect_seq("rstmid_run", 0, 2, 32'b11, 32'b10);
        rst = 1'b1;
        #1;
        check("rstmid async clk", 32'(clk_out), 32'(0));
        check("rstmid async tick", 32'(tick), 32'(0));
        expect_seq("rstmid_hold", 0, 2, 32'b00, 32'b00);
        rst = 1'b0;
        expect_seq("rstmid_re", 0, 5, 32'b11001, 32'b10001);

        // Channel 3: ratio 0 then ratio 1, channel 0 running ratio 4 alongside.
        do_reset("ch3");
        div_wr = 1'b1; div_sel = 2'd3; div_data = 16'd0;
        step();
        en = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                div_wr = 1'b1; div_sel = 2'd3; div_data = 16'd1;
            end
            step();
            check($sformatf("ch3 clk3 c%0d", k), 32'(clk_out[3]), 32'(k >= 5));
            check($sformatf("ch3 tick3 c%0d", k), 32'(tick[3]), 32'(k >= 5));
            check($sformatf("ch3 clk0 c%0d", k), 32'(clk_out[0]), 32'((k % 4) < 2));
            check($sformatf("ch3 tick0 c%0d", k), 32'(tick[0]), 32'((k % 4) == 0));
            check($sformatf("ch3 idle12 c%0d", k), 32'({clk_out[2:1], tick[2:1]}), 32'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clk_div_bank
`default_nettype wire
